// File: rtl/cache_rd_arbiter.sv
// Round-robin arbiter that shares one AXI read channel between the icache and dcache.
// Each granted request becomes one INCR burst whose beats are assembled into a 128-bit line.
module cache_rd_arbiter #(
    parameter int ID_W  = 4,
    parameter int IC_ID = 0,
    parameter int DC_ID = 1
) (
    input  logic            clk,
    input  logic            resetn,

    input  logic            ic_rd_req,
    input  logic            ic_rd_type,
    input  logic [31:0]     ic_rd_addr,
    output logic            ic_rd_rdy,
    output logic            ic_ret_valid,
    output logic [127:0]    ic_ret_data,

    input  logic            dc_rd_req,
    input  logic            dc_rd_type,
    input  logic [31:0]     dc_rd_addr,
    output logic            dc_rd_rdy,
    output logic            dc_ret_valid,
    output logic [127:0]    dc_ret_data,

    output logic [ID_W-1:0] arid,
    output logic [31:0]     araddr,
    output logic [7:0]      arlen,
    output logic [2:0]      arsize,
    output logic [1:0]      arburst,
    output logic            arvalid,
    input  logic            arready,

    input  logic [ID_W-1:0] rid,
    input  logic [31:0]     rdata,
    input  logic [1:0]      rresp,
    input  logic            rlast,
    input  logic            rvalid,
    output logic            rready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic OWN_IC = 1'b0;
    localparam logic OWN_DC = 1'b1;

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_grant_q, last_grant_d;
    logic             type_q, type_d;
    logic [31:0]      addr_q, addr_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [3:0][31:0] line_q, line_d;

    logic             ic_win;
    logic             dc_win;
    logic             grant;
    logic             beat;

    // rid and rresp carry nothing this block acts on
    logic             unused_inputs;
    assign unused_inputs = ^{rid, rresp};

    // Arbitration only happens in IDLE; on a tie the side that did not win last time goes first.
    always_comb begin
        ic_win = 1'b0;
        dc_win = 1'b0;
        if (state_q == IDLE) begin
            ic_win = ic_rd_req && (!dc_rd_req || (last_grant_q == OWN_DC));
            dc_win = dc_rd_req && (!ic_rd_req || (last_grant_q == OWN_IC));
        end
    end

    assign grant = ic_win || dc_win;
    assign beat  = (state_q == R) && rvalid;

    // Next-state logic and registered-state-derived outputs.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        type_d       = type_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;

        ic_rd_rdy    = ic_win;
        dc_rd_rdy    = dc_win;
        arvalid      = 1'b0;
        rready       = 1'b0;
        ic_ret_valid = 1'b0;
        dc_ret_valid = 1'b0;
        ic_ret_data  = '0;
        dc_ret_data  = '0;

        case (state_q)
            IDLE: begin
                if (grant) begin
                    owner_d      = dc_win ? OWN_DC : OWN_IC;
                    last_grant_d = dc_win ? OWN_DC : OWN_IC;
                    addr_d       = dc_win ? dc_rd_addr : ic_rd_addr;
                    type_d       = dc_win ? dc_rd_type : ic_rd_type;
                    cnt_d        = 2'd0;
                    state_d      = AR;
                end
            end
            AR: begin
                arvalid = 1'b1;
                if (arready) begin
                    state_d = R;
                end
            end
            R: begin
                rready = 1'b1;
                if (rvalid) begin
                    // A 2-bit counter: extra beats wrap and overwrite earlier words.
                    cnt_d = cnt_q + 2'd1;
                    if (rlast) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (owner_q == OWN_IC) begin
                    ic_ret_valid = 1'b1;
                    ic_ret_data  = line_q;
                end else begin
                    dc_ret_valid = 1'b1;
                    dc_ret_data  = line_q;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Line buffer: cleared on grant so an early rlast leaves unwritten words at zero.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_line_word
            assign line_d[gi] = grant ? 32'd0 :
                                (beat && (cnt_q == 2'(gi))) ? rdata :
                                line_q[gi];
        end
    endgenerate

    // AR fields come straight from the latched request, so they hold steady until arready.
    assign araddr  = addr_q;
    assign arlen   = type_q ? 8'd3 : 8'd0;
    assign arid    = (owner_q == OWN_DC) ? ID_W'(DC_ID) : ID_W'(IC_ID);
    assign arsize  = 3'b010;
    assign arburst = 2'b01;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            owner_q      <= OWN_IC;
            last_grant_q <= OWN_DC;
            type_q       <= 1'b0;
            addr_q       <= 32'd0;
            cnt_q        <= 2'd0;
            line_q       <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            type_q       <= type_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            line_q       <= line_d;
        end
    end

endmodule

// File: tb/tb_cache_rd_arbiter.sv
// Directed bench for cache_rd_arbiter: a table of single transactions plus
// hand-written round-robin and reset-mid-burst sequences.
module tb_cache_rd_arbiter;

    logic         clk = 1'b0;
    logic         resetn;
    logic         ic_rd_req, ic_rd_type;
    logic [31:0]  ic_rd_addr;
    logic         ic_rd_rdy, ic_ret_valid;
    logic [127:0] ic_ret_data;
    logic         dc_rd_req, dc_rd_type;
    logic [31:0]  dc_rd_addr;
    logic         dc_rd_rdy, dc_ret_valid;
    logic [127:0] dc_ret_data;
    logic [3:0]   arid;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid, arready;
    logic [3:0]   rid;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast, rvalid, rready;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cache_rd_arbiter #(.ID_W(4), .IC_ID(0), .DC_ID(1)) dut (
        .clk(clk), .resetn(resetn),
        .ic_rd_req(ic_rd_req), .ic_rd_type(ic_rd_type), .ic_rd_addr(ic_rd_addr),
        .ic_rd_rdy(ic_rd_rdy), .ic_ret_valid(ic_ret_valid), .ic_ret_data(ic_ret_data),
        .dc_rd_req(dc_rd_req), .dc_rd_type(dc_rd_type), .dc_rd_addr(dc_rd_addr),
        .dc_rd_rdy(dc_rd_rdy), .dc_ret_valid(dc_ret_valid), .dc_ret_data(dc_ret_data),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready)
    );

    typedef struct {
        logic             own;     // 0 = icache, 1 = dcache
        logic             typ;
        logic [31:0]      addr;
        int               nbeats;
        logic [4:0][31:0] d;
        int               stall;   // cycles arready stays low
        int               gap;     // idle cycles before each beat
        logic [127:0]     exp;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Never grant both sides in one cycle.
    always @(negedge clk) begin
        if (resetn === 1'b1 && (ic_rd_rdy || dc_rd_rdy))
            check("rdy_exclusive", {127'd0, ic_rd_rdy && dc_rd_rdy}, 128'd0);
    end

    // Entered at posedge+1 with the DUT in AR; leaves at posedge+1 in IDLE after RESP.
    task automatic do_ar_r(input vec_t v);
        logic [127:0] other_data;
        logic         own_valid, other_valid;
        for (int s = 0; s <= v.stall; s++) begin
            check("arvalid", {127'd0, arvalid}, 128'd1);
            check("araddr", {96'd0, araddr}, {96'd0, v.addr});
            check("arlen", {120'd0, arlen}, v.typ ? 128'd3 : 128'd0);
            check("arid", {124'd0, arid}, v.own ? 128'd1 : 128'd0);
            check("arsize_burst", {123'd0, arsize, arburst}, {123'd0, 3'b010, 2'b01});
            check("rready_in_ar", {127'd0, rready}, 128'd0);
            if (s == v.stall) arready = 1'b1;
            @(posedge clk); #1;
        end
        arready = 1'b0;
        check("rready_in_r", {127'd0, rready}, 128'd1);
        check("arvalid_in_r", {127'd0, arvalid}, 128'd0);
        for (int b = 0; b < v.nbeats; b++) begin
            for (int g = 0; g < v.gap; g++) begin
                @(posedge clk); #1;
                check("rready_gap", {127'd0, rready}, 128'd1);
                check("ret_valid_gap", {126'd0, ic_ret_valid, dc_ret_valid}, 128'd0);
            end
            rvalid = 1'b1;
            rdata  = v.d[b];
            rlast  = (b == v.nbeats - 1);
            @(posedge clk); #1;
            rvalid = 1'b0;
            rlast  = 1'b0;
        end
        own_valid   = v.own ? dc_ret_valid : ic_ret_valid;
        other_valid = v.own ? ic_ret_valid : dc_ret_valid;
        other_data  = v.own ? ic_ret_data  : dc_ret_data;
        check("ret_valid_owner", {127'd0, own_valid}, 128'd1);
        check("ret_valid_other", {127'd0, other_valid}, 128'd0);
        check("ret_data", v.own ? dc_ret_data : ic_ret_data, v.exp);
        check("ret_data_other", other_data, 128'd0);
        check("rdy_in_resp", {126'd0, ic_rd_rdy, dc_rd_rdy}, 128'd0);
        @(posedge clk); #1;
        check("ret_valid_pulse", {126'd0, ic_ret_valid, dc_ret_valid}, 128'd0);
        check("rready_idle", {127'd0, rready}, 128'd0);
    endtask

    task automatic run_txn(input int idx);
        vec_t v;
        v = vecs[idx];
        @(posedge clk); #1;
        if (v.own) begin
            dc_rd_req = 1'b1; dc_rd_type = v.typ; dc_rd_addr = v.addr;
        end else begin
            ic_rd_req = 1'b1; ic_rd_type = v.typ; ic_rd_addr = v.addr;
        end
        #1;
        check("rdy_grant", {126'd0, ic_rd_rdy, dc_rd_rdy}, v.own ? 128'd1 : 128'd2);
        @(posedge clk); #1;
        ic_rd_req = 1'b0;
        dc_rd_req = 1'b0;
        do_ar_r(v);
        $display("txn %0d own=%0d type=%0d addr=%h ret=%h", idx, v.own, v.typ, v.addr,
                 v.own ? dc_ret_data : ic_ret_data);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t sim_ic, sim_dc;

        vecs[0] = '{own:1'b0, typ:1'b1, addr:32'h1FC0_0010, nbeats:4,
                    d:{32'h0, 32'h44, 32'h33, 32'h22, 32'h11}, stall:0, gap:0,
                    exp:128'h00000044_00000033_00000022_00000011};
        vecs[1] = '{own:1'b1, typ:1'b0, addr:32'hBFAF_8004, nbeats:1,
                    d:{32'h0, 32'h0, 32'h0, 32'h0, 32'hDEADBEEF}, stall:0, gap:0,
                    exp:{96'd0, 32'hDEADBEEF}};
        vecs[2] = '{own:1'b0, typ:1'b1, addr:32'h0000_1000, nbeats:4,
                    d:{32'h0, 32'h4, 32'h3, 32'h2, 32'h1}, stall:5, gap:0,
                    exp:128'h00000004_00000003_00000002_00000001};
        vecs[3] = '{own:1'b1, typ:1'b1, addr:32'h0000_2000, nbeats:4,
                    d:{32'h0, 32'h4, 32'h3, 32'h2, 32'h1}, stall:0, gap:2,
                    exp:128'h00000004_00000003_00000002_00000001};
        vecs[4] = '{own:1'b0, typ:1'b1, addr:32'h0000_3000, nbeats:2,
                    d:{32'h0, 32'h0, 32'h0, 32'hB, 32'hA}, stall:1, gap:1,
                    exp:128'h00000000_00000000_0000000B_0000000A};
        vecs[5] = '{own:1'b1, typ:1'b1, addr:32'h0000_4000, nbeats:5,
                    d:{32'h5, 32'h4, 32'h3, 32'h2, 32'h1}, stall:0, gap:0,
                    exp:128'h00000004_00000003_00000002_00000005};
        vecs[6] = '{own:1'b0, typ:1'b0, addr:32'h0000_0044, nbeats:1,
                    d:{32'h0, 32'h0, 32'h0, 32'h0, 32'h12345678}, stall:2, gap:0,
                    exp:{96'd0, 32'h12345678}};
        vecs[7] = '{own:1'b1, typ:1'b1, addr:32'h8000_0040, nbeats:4,
                    d:{32'h0, 32'hCAFE0004, 32'hCAFE0003, 32'hCAFE0002, 32'hCAFE0001},
                    stall:0, gap:0,
                    exp:128'hCAFE0004_CAFE0003_CAFE0002_CAFE0001};

        resetn = 1'b0;
        ic_rd_req = 1'b0; ic_rd_type = 1'b0; ic_rd_addr = 32'd0;
        dc_rd_req = 1'b0; dc_rd_type = 1'b0; dc_rd_addr = 32'd0;
        arready = 1'b0; rid = 4'd0; rdata = 32'd0; rresp = 2'd0;
        rlast = 1'b0; rvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        check("reset_arvalid", {127'd0, arvalid}, 128'd0);
        check("reset_rready", {127'd0, rready}, 128'd0);
        check("reset_ret_valid", {126'd0, ic_ret_valid, dc_ret_valid}, 128'd0);
        check("reset_ic_data", ic_ret_data, 128'd0);
        check("reset_dc_data", dc_ret_data, 128'd0);
        check("reset_rdy", {126'd0, ic_rd_rdy, dc_rd_rdy}, 128'd0);
        $display("txn reset: arvalid=%0d rready=%0d", arvalid, rready);

        // Both caches hold requests through three rounds: ic, dc, ic.
        sim_ic = '{own:1'b0, typ:1'b1, addr:32'h0000_0100, nbeats:4,
                   d:{32'h0, 32'hA4, 32'hA3, 32'hA2, 32'hA1}, stall:0, gap:0,
                   exp:128'h000000A4_000000A3_000000A2_000000A1};
        sim_dc = '{own:1'b1, typ:1'b1, addr:32'h0000_0200, nbeats:4,
                   d:{32'h0, 32'hB4, 32'hB3, 32'hB2, 32'hB1}, stall:0, gap:0,
                   exp:128'h000000B4_000000B3_000000B2_000000B1};
        @(posedge clk); #1;
        ic_rd_req = 1'b1; ic_rd_type = 1'b1; ic_rd_addr = sim_ic.addr;
        dc_rd_req = 1'b1; dc_rd_type = 1'b1; dc_rd_addr = sim_dc.addr;
        for (int round = 0; round < 3; round++) begin
            vec_t sv;
            sv = (round == 1) ? sim_dc : sim_ic;
            #1;
            check("rr_grant", {126'd0, ic_rd_rdy, dc_rd_rdy}, sv.own ? 128'd1 : 128'd2);
            @(posedge clk); #1;
            check("rdy_in_ar", {126'd0, ic_rd_rdy, dc_rd_rdy}, 128'd0);
            do_ar_r(sv);
            $display("txn rr%0d own=%0d ret=%h", round, sv.own,
                     sv.own ? dc_ret_data : ic_ret_data);
        end
        ic_rd_req = 1'b0;
        dc_rd_req = 1'b0;

        for (int i = 0; i < 7; i++) run_txn(i);

        // Reset after two of four beats of an icache line.
        @(posedge clk); #1;
        ic_rd_req = 1'b1; ic_rd_type = 1'b1; ic_rd_addr = 32'h0000_5000;
        @(posedge clk); #1;
        ic_rd_req = 1'b0;
        check("rst_seq_arvalid", {127'd0, arvalid}, 128'd1);
        arready = 1'b1;
        @(posedge clk); #1;
        arready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            rvalid = 1'b1; rdata = 32'h7700 + b;
            @(posedge clk); #1;
        end
        rvalid = 1'b0;
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        check("rst_rready", {127'd0, rready}, 128'd0);
        check("rst_arvalid", {127'd0, arvalid}, 128'd0);
        check("rst_ret_valid", {126'd0, ic_ret_valid, dc_ret_valid}, 128'd0);
        // A stray beat with rlast must not be taken.
        rvalid = 1'b1; rdata = 32'hFFFF_FFFF; rlast = 1'b1;
        #1;
        check("stray_rready", {127'd0, rready}, 128'd0);
        @(posedge clk); #1;
        rvalid = 1'b0; rlast = 1'b0;
        check("stray_ret_valid", {126'd0, ic_ret_valid, dc_ret_valid}, 128'd0);
        @(posedge clk); #1;
        check("stray_ret_valid2", {126'd0, ic_ret_valid, dc_ret_valid}, 128'd0);
        $display("txn reset-mid-R: rready=%0d ret_valid=%0d/%0d", rready, ic_ret_valid, dc_ret_valid);
        run_txn(7);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
